// File: rtl/weightmemory_burst_loader.sv
// Burst engine: turns one (write|read, addr, len) command into single-word accesses on the
// weight memory external port, with a credit-controlled return FIFO for read data.
module weightmemory_burst_loader #(
   parameter int unsigned BANKDEPTH     = 1024,
   parameter int unsigned WORDWIDTH     = 104,
   parameter int unsigned RD_FIFO_DEPTH = 2,
   localparam int unsigned ADDRW        = $clog2(BANKDEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic                 cmd_write_i,
   input  logic [ADDRW-1:0]     cmd_addr_i,
   input  logic [ADDRW:0]       cmd_len_i,
   input  logic                 wdata_valid_i,
   output logic                 wdata_ready_o,
   input  logic [WORDWIDTH-1:0] wdata_i,
   output logic                 rdata_valid_o,
   input  logic                 rdata_ready_i,
   output logic [WORDWIDTH-1:0] rdata_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [ADDRW-1:0]     mem_addr_o,
   output logic [WORDWIDTH-1:0] mem_wdata_o,
   input  logic [WORDWIDTH-1:0] mem_rdata_i,
   input  logic                 mem_rvalid_i,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int unsigned LENW = ADDRW + 1;
   localparam int unsigned PTRW = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
   localparam int unsigned CNTW = $clog2(RD_FIFO_DEPTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [ADDRW-1:0]     addr_q, addr_d;
   logic [LENW-1:0]      rem_q, rem_d;
   logic                 out_q, out_d;
   logic                 done_q, done_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic [PTRW-1:0]      rptr_q, rptr_d;
   logic [PTRW-1:0]      wptr_q, wptr_d;
   logic [WORDWIDTH-1:0] fifo_q [RD_FIFO_DEPTH];

   logic                 push, pop, rd_issue;
   logic [ADDRW-1:0]     addr_inc;
   logic [CNTW:0]        credit_used;

   // A response only counts when a request is actually in flight.
   assign push     = mem_rvalid_i & out_q;
   assign pop      = (cnt_q != '0) & rdata_ready_i;
   assign addr_inc = (addr_q == ADDRW'(BANKDEPTH - 1)) ? '0 : addr_q + ADDRW'(1);

   // Slots committed next cycle; a same-cycle pop frees one, keeping full read throughput.
   assign credit_used = (CNTW+1)'(cnt_q) + (CNTW+1)'(out_q) - (CNTW+1)'(pop);
   assign rd_issue    = (state_q == S_READ) && (credit_used < (CNTW+1)'(RD_FIFO_DEPTH));

   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = done_q;
   assign rdata_valid_o = (cnt_q != '0);
   assign rdata_o       = fifo_q[rptr_q];

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      rem_d         = rem_q;
      out_d         = out_q;
      done_d        = 1'b0;
      cmd_ready_o   = 1'b0;
      wdata_ready_o = 1'b0;
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      mem_addr_o    = '0;
      mem_wdata_o   = '0;

      if (push) out_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               addr_d = cmd_addr_i;
               rem_d  = cmd_len_i;
               if (cmd_len_i == '0) done_d = 1'b1;
               else                 state_d = cmd_write_i ? S_WRITE : S_READ;
            end
         end
         S_WRITE: begin
            wdata_ready_o = 1'b1;
            mem_req_o     = wdata_valid_i;
            mem_we_o      = wdata_valid_i;
            mem_addr_o    = addr_q;
            mem_wdata_o   = wdata_i;
            if (wdata_valid_i) begin
               addr_d = addr_inc;
               rem_d  = rem_q - LENW'(1);
               if (rem_q == LENW'(1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         S_READ: begin
            mem_addr_o = addr_q;
            if (rd_issue) begin
               mem_req_o = 1'b1;
               out_d     = 1'b1;
               addr_d    = addr_inc;
               rem_d     = rem_q - LENW'(1);
               if (rem_q == LENW'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (push) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Return FIFO bookkeeping.
   always_comb begin
      cnt_d  = cnt_q + CNTW'(push) - CNTW'(pop);
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) wptr_d = (wptr_q == PTRW'(RD_FIFO_DEPTH - 1)) ? '0 : wptr_q + PTRW'(1);
      if (pop)  rptr_d = (rptr_q == PTRW'(RD_FIFO_DEPTH - 1)) ? '0 : rptr_q + PTRW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         out_q   <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         rptr_q  <= '0;
         wptr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         out_q   <= out_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(RD_FIFO_DEPTH); i++) fifo_q[i] <= '0;
      end else if (push) begin
         fifo_q[wptr_q] <= mem_rdata_i;
      end
   end

endmodule

// File: tb/tb_weightmemory_burst_loader.sv
// Scoreboard bench for weightmemory_burst_loader with a 1-cycle-latency weight memory model.
module tb_weightmemory_burst_loader;

   localparam int unsigned BANKDEPTH = 1024;
   localparam int unsigned WORDWIDTH = 104;
   localparam int unsigned ADDRW     = 10;

   typedef struct {
      logic                 we;
      logic [ADDRW-1:0]     addr;
      logic [WORDWIDTH-1:0] data;
   } req_t;

   logic                 clk = 1'b0;
   logic                 rst_i;
   logic                 cmd_valid_i, cmd_ready_o, cmd_write_i;
   logic [ADDRW-1:0]     cmd_addr_i;
   logic [ADDRW:0]       cmd_len_i;
   logic                 wdata_valid_i, wdata_ready_o;
   logic [WORDWIDTH-1:0] wdata_i;
   logic                 rdata_valid_o, rdata_ready_i;
   logic [WORDWIDTH-1:0] rdata_o;
   logic                 mem_req_o, mem_we_o;
   logic [ADDRW-1:0]     mem_addr_o;
   logic [WORDWIDTH-1:0] mem_wdata_o;
   logic [WORDWIDTH-1:0] mem_rdata = '0;
   logic                 mem_rvalid = 1'b0;
   logic                 busy_o, done_o;

   int checks = 0, errors = 0;
   int cyc = 0, done_cnt = 0, wr_cnt = 0, rd_issued = 0, beats = 0, req_cnt = 0;
   int inflight = 0, max_inflight = 0;
   int beat_cyc[$];
   req_t exp_req[$];
   logic [WORDWIDTH-1:0] exp_rd[$];
   logic [WORDWIDTH-1:0] shadow [BANKDEPTH];
   logic [WORDWIDTH-1:0] mem_model [BANKDEPTH];
   logic [WORDWIDTH-1:0] wbuf [16];
   req_t mon_req;
   logic [WORDWIDTH-1:0] mon_rd;

   weightmemory_burst_loader dut (
      .clk_i(clk), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
      .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
      .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
      .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Weight memory model: always grants, read data one cycle later.
   always @(posedge clk) begin
      mem_rvalid <= mem_req_o & ~mem_we_o;
      mem_rdata  <= mem_model[mem_addr_o];
      if (mem_req_o & mem_we_o) mem_model[mem_addr_o] <= mem_wdata_o;
   end

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Monitor: memory requests and read beats against the scoreboard.
   always @(negedge clk) begin
      if (mem_req_o) begin
         req_cnt++;
         if (mem_we_o) begin
            wr_cnt++;
            check("we_needs_valid", 128'(wdata_valid_i), 128'(1));
         end else begin
            rd_issued++;
         end
         if (exp_req.size() == 0) begin
            check("req_unexpected", 128'(mem_addr_o), 128'(-1));
         end else begin
            mon_req = exp_req.pop_front();
            check("req_we", 128'(mem_we_o), 128'(mon_req.we));
            check("req_addr", 128'(mem_addr_o), 128'(mon_req.addr));
            if (mon_req.we) check("req_wdata", 128'(mem_wdata_o), 128'(mon_req.data));
         end
      end
      if (rdata_valid_o && rdata_ready_i) begin
         beats++;
         beat_cyc.push_back(cyc);
         if (exp_rd.size() == 0) begin
            check("rd_unexpected", 128'(rdata_o), 128'(-1));
         end else begin
            mon_rd = exp_rd.pop_front();
            check("rdata", 128'(rdata_o), 128'(mon_rd));
         end
      end
      if (rst_i) begin
         inflight = 0;
      end else begin
         if (inflight > max_inflight) max_inflight = inflight;
         if (mem_req_o && !mem_we_o) inflight++;
         if (rdata_valid_o && rdata_ready_i) inflight--;
      end
      if (done_o) done_cnt++;
   end

   task automatic issue_cmd(input logic wr, input int addr, input int len);
      for (int k = 0; k < 50 && !cmd_ready_o; k++) begin
         @(posedge clk); #1;
      end
      if (!cmd_ready_o) check("cmd_ready_timeout", 128'(0), 128'(1));
      cmd_valid_i = 1'b1;
      cmd_write_i = wr;
      cmd_addr_i  = ADDRW'(addr);
      cmd_len_i   = (ADDRW+1)'(len);
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
   endtask

   // mask bit k = wdata_valid in data cycle k (k < mlen); afterwards always valid.
   task automatic write_burst(input int addr, input int len, input int mask, input int mlen);
      int n = 0;
      int a;
      logic v;
      issue_cmd(1'b1, addr, len);
      for (int k = 0; k < 200 && n < len; k++) begin
         v = (k < mlen) ? mask[k] : 1'b1;
         wdata_valid_i = v;
         wdata_i       = wbuf[n];
         if (v) begin
            a = (addr + n) % int'(BANKDEPTH);
            exp_req.push_back('{1'b1, ADDRW'(a), wbuf[n]});
            shadow[a] = wbuf[n];
         end
         @(posedge clk); #1;
         if (v) n++;
      end
      wdata_valid_i = 1'b0;
   endtask

   task automatic read_burst(input int addr, input int len);
      int a;
      for (int n = 0; n < len; n++) begin
         a = (addr + n) % int'(BANKDEPTH);
         exp_req.push_back('{1'b0, ADDRW'(a), '0});
         exp_rd.push_back(shadow[a]);
      end
      issue_cmd(1'b0, addr, len);
   endtask

   task automatic wait_done(input int d0, input int budget, input bit toggle);
      for (int k = 0; k < budget && done_cnt == d0; k++) begin
         @(posedge clk); #1;
         if (toggle) rdata_ready_i = ~rdata_ready_i;
      end
      if (done_cnt == d0) check("done_timeout", 128'(0), 128'(1));
      rdata_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int d0, w0, b0, r0, q0;
      rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
      wdata_valid_i = 1'b0; wdata_i = '0; rdata_ready_i = 1'b1;
      for (int i = 0; i < int'(BANKDEPTH); i++) shadow[i] = '0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;

      @(negedge clk);
      check("rst_cmd_ready", 128'(cmd_ready_o), 128'(1));
      check("rst_busy", 128'(busy_o), 128'(0));
      check("rst_done", 128'(done_o), 128'(0));
      check("rst_mem_req", 128'(mem_req_o), 128'(0));
      check("rst_wdata_ready", 128'(wdata_ready_o), 128'(0));
      check("rst_rdata_valid", 128'(rdata_valid_o), 128'(0));
      check("rst_rdata", 128'(rdata_o), 128'(0));
      @(posedge clk); #1;

      // Write addr 5 len 4, back-to-back
      for (int i = 0; i < 4; i++) wbuf[i] = WORDWIDTH'(32'hA + i);
      d0 = done_cnt; w0 = wr_cnt;
      write_burst(5, 4, 0, 0);
      wait_done(d0, 20, 1'b0);
      check("wr_done_pulses", 128'(done_cnt - d0), 128'(1));
      check("wr_req_cycles", 128'(wr_cnt - w0), 128'(4));
      check("wr_busy_after", 128'(busy_o), 128'(0));

      // Read addr 5 len 4, host always ready: gap-free beats
      d0 = done_cnt; b0 = beats;
      read_burst(5, 4);
      wait_done(d0, 30, 1'b0);
      check("rd_done_pulses", 128'(done_cnt - d0), 128'(1));
      check("rd_beats", 128'(beats - b0), 128'(4));
      check("rd_no_gaps", 128'(beat_cyc[$] - beat_cyc[$-3]), 128'(3));
      check("rd_sb_empty", 128'(exp_rd.size()), 128'(0));

      // Read len 8 with host ready toggling
      for (int i = 0; i < 8; i++) wbuf[i] = {8'hC3, 64'h0, 32'h5A5A_0000 + 32'(i * 7)};
      d0 = done_cnt;
      write_burst(20, 8, 0, 0);
      wait_done(d0, 30, 1'b0);
      d0 = done_cnt; b0 = beats;
      rdata_ready_i = 1'b0;
      read_burst(20, 8);
      wait_done(d0, 60, 1'b1);
      check("tog_done_pulses", 128'(done_cnt - d0), 128'(1));
      check("tog_beats", 128'(beats - b0), 128'(8));
      check("tog_sb_empty", 128'(exp_rd.size()), 128'(0));
      check("max_inflight", 128'(max_inflight), 128'(2));

      // Address wrap
      for (int i = 0; i < 4; i++) wbuf[i] = WORDWIDTH'(32'h7700 + i);
      d0 = done_cnt; w0 = wr_cnt;
      write_burst(1022, 4, 0, 0);
      wait_done(d0, 20, 1'b0);
      check("wrap_done_pulses", 128'(done_cnt - d0), 128'(1));
      check("wrap_req_cycles", 128'(wr_cnt - w0), 128'(4));

      // Zero-length command
      d0 = done_cnt; q0 = req_cnt;
      issue_cmd(1'b1, 7, 0);
      @(negedge clk);
      check("len0_done_next", 128'(done_o), 128'(1));
      check("len0_busy", 128'(busy_o), 128'(0));
      @(negedge clk);
      check("len0_done_once", 128'(done_o), 128'(0));
      check("len0_no_req", 128'(req_cnt - q0), 128'(0));
      @(posedge clk); #1;

      // Reset mid read burst (2 of 6 issued, host stalled)
      rdata_ready_i = 1'b0;
      r0 = rd_issued; d0 = done_cnt;
      read_burst(100, 6);
      @(posedge clk); #1 rst_i = 1'b1;
      @(posedge clk); #1 rst_i = 1'b0;
      exp_req.delete();
      exp_rd.delete();
      check("rst_mid_issued", 128'(rd_issued - r0), 128'(2));
      @(negedge clk);
      check("rst_mid_busy", 128'(busy_o), 128'(0));
      check("rst_mid_cmd_ready", 128'(cmd_ready_o), 128'(1));
      check("rst_mid_fifo_empty", 128'(rdata_valid_o), 128'(0));
      @(negedge clk);
      check("rst_stray_ignored", 128'(rdata_valid_o), 128'(0));
      check("rst_mid_no_done", 128'(done_cnt - d0), 128'(0));
      @(posedge clk); #1;
      rdata_ready_i = 1'b1;

      // Write with host gaps 1,0,0,1,1 then read back
      for (int i = 0; i < 3; i++) wbuf[i] = {8'h3C, 64'hFFFF_0000_FFFF_0000, 32'(i + 1)};
      d0 = done_cnt; w0 = wr_cnt;
      write_burst(200, 3, 32'b11001, 5);
      wait_done(d0, 20, 1'b0);
      check("gap_req_cycles", 128'(wr_cnt - w0), 128'(3));
      check("gap_done_pulses", 128'(done_cnt - d0), 128'(1));
      d0 = done_cnt; b0 = beats;
      read_burst(200, 3);
      wait_done(d0, 30, 1'b0);
      check("gap_readback_beats", 128'(beats - b0), 128'(3));

      check("req_sb_empty", 128'(exp_req.size()), 128'(0));
      check("rd_sb_empty_end", 128'(exp_rd.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
